// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC transmit arbiter.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_e;

    // Ceiling log2 for sizing index and counter fields.
    function automatic int unsigned log2_ceil(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdc_sync_ff.sv
// Multi-flop level synchronizer, reset to 0; used for toggle handshake lines.
module cdc_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cdc_tx_arbiter.sv
// Round-robin arbiter feeding one toggle-handshake CDC channel, one transfer in flight.
// Optional feature: define CDC_ARB_TIMEOUT_EN to abandon a transfer whose ack never returns.
module cdc_tx_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned DATAWIDTH      = 8,
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*DATAWIDTH-1:0]   req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic [DATAWIDTH-1:0]        src2dest_data,
    output logic                        src2dest_load,
    input  logic                        dest2src_ack,
    output logic                        busy,
    output logic [log2_ceil(NREQ)-1:0]  grant_id,
    output logic                        timeout_err
);

    localparam int unsigned IDW  = log2_ceil(NREQ);
    localparam int unsigned IDX1 = IDW + 1;

    // Reject unsupported configurations at elaboration.
    if (NREQ < 2 || NREQ > 16 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cdc_tx_arbiter: unsupported parameter value");
    end

    arb_state_e           state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       pick_c;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic [NREQ-1:0]      ready_q, ready_d;
    logic                 load_q, load_d;
    logic                 busy_q, busy_d;
    logic                 ack_sync, ack_prev_q;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int unsigned CNTW = log2_ceil(TIMEOUT_CYCLES + 1);
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            tmo_q, tmo_d;
`endif

    cdc_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .CLK  (CLK),
        .RSTn (RSTn),
        .d    (dest2src_ack),
        .q    (ack_sync)
    );

    // First requester at or after start, wrapping modulo NREQ.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                                input logic [IDW-1:0]  start);
        logic [IDW-1:0] pick;
        logic [IDX1-1:0] idx;
        logic           found;
        pick  = start;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, start} + IDX1'(i);
            if (idx >= IDX1'(NREQ)) idx = idx - IDX1'(NREQ);
            if (!found && valid[idx[IDW-1:0]]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
        return pick;
    endfunction

    assign pick_c = rr_pick(req_valid, ptr_q);

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state, grant selection and channel updates.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        load_d  = load_q;
        ready_d = '0;
`ifdef CDC_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    data_d          = req_data[32'(pick_c)*DATAWIDTH +: DATAWIDTH];
                    ready_d[pick_c] = 1'b1;
                    grant_d         = pick_c;
                    ptr_d           = (pick_c == IDW'(NREQ-1)) ? '0 : pick_c + IDW'(1);
                    state_d         = LAUNCH;
                end
            end
            LAUNCH: begin
                load_d  = ~load_q;
                state_d = WAIT_ACK;
`ifdef CDC_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT_ACK: begin
                if (ack_sync != ack_prev_q) begin
                    state_d = IDLE;
                end
`ifdef CDC_ARB_TIMEOUT_EN
                else if (cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Datapath and output registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ptr_q      <= '0;
            grant_q    <= '0;
            data_q     <= '0;
            load_q     <= 1'b0;
            ready_q    <= '0;
            busy_q     <= 1'b0;
            ack_prev_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            data_q     <= data_d;
            load_q     <= load_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            ack_prev_q <= ack_sync;
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    // Ack-wait counter and timeout pulse.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign req_ready     = ready_q;
    assign src2dest_data = data_q;
    assign src2dest_load = load_q;
    assign busy          = busy_q;
    assign grant_id      = grant_q;

endmodule

// File: doc/cdc_tx_arbiter.md
Name: cdc_tx_arbiter

Overview:
Source-domain arbiter that shares one toggle-handshake CDC channel among NREQ requesters. Round-robin selection of one request at a time. Registers the winning data onto the channel and toggles the load line. Waits for the destination's acknowledge toggle before granting again, so only one transfer is in flight. Sits in the CLK domain, between local requesters and the destination-domain receiver.

Parameters:
NREQ, 4, number of requesters (2..16; non-power-of-two allowed)
DATAWIDTH, 8, payload width
SYNC_STAGES, 2, flops in the ack synchronizer (>=2)
TIMEOUT_CYCLES, 255, WAIT_ACK limit; used only with CDC_ARB_TIMEOUT_EN

Ports:
CLK  in  1  source clock
RSTn  in  1  asynchronous, active-low reset
req_valid  in  NREQ  per-requester request
req_data  in  NREQ*DATAWIDTH  payload; requester i occupies bits [i*DATAWIDTH +: DATAWIDTH]
req_ready  out  NREQ  one-cycle registered accept pulse, one-hot
src2dest_data  out  DATAWIDTH  channel data, held stable while in flight
src2dest_load  out  1  toggle; each transition = one new word
dest2src_ack  in  1  ack toggle from destination domain (asynchronous)
busy  out  1  high in LAUNCH and WAIT_ACK
grant_id  out  $clog2(NREQ)  index of last granted requester
timeout_err  out  1  one-cycle pulse on ack timeout; constant 0 without the macro

Behaviour:
- Reset: state=IDLE, ptr=0, req_ready=0, src2dest_data=0, src2dest_load=0, busy=0, grant_id=0, timeout_err=0, ack synchronizer and ack_prev=0, timeout counter=0. Both domains are reset together (system requirement).
- Requester rule: hold req_valid and req_data stable until its req_ready pulse; it may drop or change them from the next edge.
- FSM states: IDLE, LAUNCH, WAIT_ACK.
- IDLE: if any req_valid bit is set at edge k, grant g = first i in ptr, ptr+1, … (mod NREQ) with req_valid[i]=1. At edge k: src2dest_data<=req_data[g]; req_ready[g]<=1 for exactly one cycle; grant_id<=g; ptr<=(g+1) mod NREQ; state<=LAUNCH. If no request is set, stay in IDLE.
- LAUNCH: at edge k+1, src2dest_load inverts and state<=WAIT_ACK. Data is therefore stable for at least 1 cycle before the toggle.
- WAIT_ACK: ack_sync = SYNC_STAGES-flop synchronized dest2src_ack, and ack_prev<=ack_sync every cycle in every state. When ack_sync!=ack_prev, state<=IDLE. The earliest next grant is on the following edge.
- src2dest_data and src2dest_load do not change outside the IDLE->LAUNCH and LAUNCH->WAIT_ACK edges.
- An ack edge that arrives in IDLE or LAUNCH is tracked in ack_prev but ignored. It never completes a later transfer.
- req_valid is sampled only in IDLE. Requests that arrive or are dropped while busy have no effect.
- Minimum transfer period: 3 + SYNC_STAGES + destination ack latency.
- Reset mid-transfer aborts immediately to the reset values. No load toggle is emitted.

Optional Feature:
CDC_ARB_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT_ACK and increments each cycle there. If it reaches TIMEOUT_CYCLES without an ack edge, then:
  - timeout_err pulses for 1 cycle;
  - state<=IDLE;
  - ptr is unchanged (it already advanced at grant);
  - no re-toggle is issued.
- If the ack edge and the timeout occur in the same cycle, the ack wins and there is no error.
- Undefined: no counter; WAIT_ACK waits indefinitely; timeout_err is tied to 0.

Decomposition:
- Package cdc_arb_pkg: FSM state encodings (IDLE=2'd0, LAUNCH=2'd1, WAIT_ACK=2'd2) and a log2 helper constant function.
- Sub-module cdc_sync_ff (SYNC_STAGES-deep, reset to 0) for dest2src_ack. It is reusable by the destination side for the load toggle.
- The round-robin pick is a combinational function inside the arbiter.

Test Plan:
- Single request: req_valid=4'b0100, data 0xA5 → req_ready=4'b0100 for 1 cycle, src2dest_data=0xA5, load 0→1 one cycle later, busy until ack toggle returns.
- All requests held at 4'b1111, ack model 3 cycles → grants in order 0,1,2,3,0; load toggles once per grant.
- Fairness: after a grant to 2, requests 4'b1001 → grant 3 next, then 0.
- Spurious ack toggle while in IDLE, then request 4'b0001 → the transfer waits for a fresh ack edge and does not complete early.
- With CDC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, ack withheld → timeout_err pulses 8 cycles after entering WAIT_ACK; pending request 4'b0010 is then granted.
- RSTn asserted mid-WAIT_ACK → all outputs are 0 immediately; after release, a request 4'b0001 is granted with ptr=0.
